tm_frame_randomizer: RTL and testbench

- Bit-serial stage directly downstream of the TTC byte-to-bit serializer.
- Consumes its MSB-first bit stream and bit-valid strobe, one bit per clock.
- Passes the leading attached sync marker (ASM) bits unchanged and XORs every following bit with the CCSDS pseudo-random sequence.
- Checks frame length and drives the line-coded bit to the modulator interface.

---
 rtl/tm_frame_randomizer.sv | 94 +++++++++
 tb/tb_tm_frame_randomizer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tm_frame_randomizer.sv
// rtl/tm_frame_randomizer.sv - CCSDS TM bit-serial randomizer with ASM bypass and frame length check
// Optional NRZ-M line coding: define TM_FRAME_RANDOMIZER_NRZM_EN.
module tm_frame_randomizer #(
  parameter int ASM_BITS   = 32,
  parameter int FRAME_BITS = 2048
) (
  input  logic        ClkI,
  input  logic        Rst,
  input  logic        EnI,
  input  logic        DataI,
  output logic        DataO,
  output logic        EnO,
  output logic        FrameDone,
  output logic        LenErr,
  output logic [15:0] BitCountO
);

  typedef enum logic [1:0] {IDLE, ASM, DATA} state_t;

  localparam logic [15:0] FRAME_LEN = 16'(FRAME_BITS);
  localparam logic [15:0] ASM_LEN   = 16'(ASM_BITS);
  localparam logic [7:0]  LFSR_SEED = 8'hFF;

  state_t      state, stateNxt, effState;
  logic [15:0] bitCnt, bitCntNxt;
  logic [7:0]  lfsr, lfsrNxt;
  logic        codedBit, dataNxt, frameEnd;

  // bitCnt is always 0 in IDLE, so the first bit of a frame sees counter 0.
  always_comb begin
    stateNxt  = state;
    bitCntNxt = bitCnt;
    lfsrNxt   = lfsr;
    codedBit  = 1'b0;
    frameEnd  = 1'b0;
    effState  = state;
    if (state == IDLE) begin
      effState = (ASM_BITS > 0) ? ASM : DATA;
    end
    if (EnI) begin
      bitCntNxt = (bitCnt == 16'hFFFF) ? bitCnt : bitCnt + 16'd1;
      stateNxt  = effState;
      if (effState == ASM) begin
        codedBit = DataI;
        lfsrNxt  = LFSR_SEED;
        if (bitCntNxt >= ASM_LEN) begin
          stateNxt = DATA;
        end
      end else if (bitCnt >= FRAME_LEN) begin
        codedBit = DataI;
      end else begin
        // Window of a(n)..a(n+7) with a(n) in bit 7; a(n+8)=a(n+7)^a(n+5)^a(n+3)^a(n).
        codedBit = DataI ^ lfsr[7];
        lfsrNxt  = {lfsr[6:0], lfsr[7] ^ lfsr[4] ^ lfsr[2] ^ lfsr[0]};
      end
    end else if (state != IDLE) begin
      frameEnd  = 1'b1;
      stateNxt  = IDLE;
      bitCntNxt = 16'd0;
      lfsrNxt   = LFSR_SEED;
    end
  end

`ifdef TM_FRAME_RANDOMIZER_NRZM_EN
  assign dataNxt = EnI ? (DataO ^ codedBit) : DataO;
`else
  assign dataNxt = EnI & codedBit;
`endif

  always_ff @(posedge ClkI) begin
    if (Rst) begin
      state     <= IDLE;
      bitCnt    <= 16'd0;
      lfsr      <= LFSR_SEED;
      DataO     <= 1'b0;
      EnO       <= 1'b0;
      FrameDone <= 1'b0;
      LenErr    <= 1'b0;
      BitCountO <= 16'd0;
    end else begin
      state     <= stateNxt;
      bitCnt    <= bitCntNxt;
      lfsr      <= lfsrNxt;
      DataO     <= dataNxt;
      EnO       <= EnI;
      FrameDone <= frameEnd;
      if (frameEnd) begin
        BitCountO <= bitCnt;
        LenErr    <= (bitCnt != FRAME_LEN);
      end
    end
  end

endmodule

// File: tb/tb_tm_frame_randomizer.sv
// tb/tb_tm_frame_randomizer.sv - self-checking bench for tm_frame_randomizer
module tb_tm_frame_randomizer;

  localparam int ASM  = 32;
  localparam int FB   = 2048;
  localparam int MAXB = 2200;

  logic        ClkI = 1'b0;
  logic        Rst = 1'b1;
  logic        EnI = 1'b0;
  logic        DataI = 1'b0;
  logic        DataO, EnO, FrameDone, LenErr;
  logic [15:0] BitCountO;

  int checks = 0;
  int failures = 0;

  tm_frame_randomizer #(.ASM_BITS(ASM), .FRAME_BITS(FB)) dut (
    .ClkI(ClkI), .Rst(Rst), .EnI(EnI), .DataI(DataI),
    .DataO(DataO), .EnO(EnO), .FrameDone(FrameDone),
    .LenErr(LenErr), .BitCountO(BitCountO)
  );

  always #5 ClkI = ~ClkI;

  typedef struct {
    int         oct;
    logic [7:0] expOct;
  } vec_t;
  vec_t vecs[12];

  bit pn[255];
  bit din[MAXB];
  bit capt[MAXB];
  bit capRaw[MAXB];
  int capIdx = 0;
  logic dutPrev = 1'b0;

  // Reference model state: frame membership and bit index, plus expected outputs.
  bit          mInFrame = 0;
  int          mIdx = 0;
  bit          mLevel = 0;
  logic        eData, eEn, eDone, eLen;
  logic [15:0] eCnt;
  bit          armed = 0;
  int          cycErr = 0;
  string       firstMsg = "";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic flush(input string name);
    checks++;
    if (cycErr != 0) begin
      failures++;
      $display("FAIL %s bad_cycles=%0d first %s", name, cycErr, firstMsg);
    end
    cycErr = 0;
  endtask

  task automatic step(input bit r, input bit en, input bit d);
    bit coded;
    int k;
    @(negedge ClkI);
    if (armed && ({DataO, EnO, FrameDone, LenErr, BitCountO} !== {eData, eEn, eDone, eLen, eCnt})) begin
      if (cycErr == 0)
        firstMsg = $sformatf("t=%0t actual d/en/done/len/cnt=%b%b%b%b/%0d required=%b%b%b%b/%0d",
                             $time, DataO, EnO, FrameDone, LenErr, BitCountO, eData, eEn, eDone, eLen, eCnt);
      cycErr++;
    end
    if (EnO === 1'b1) begin
      if (capIdx < MAXB) begin
`ifdef TM_FRAME_RANDOMIZER_NRZM_EN
        capt[capIdx] = DataO ^ dutPrev;
`else
        capt[capIdx] = DataO;
`endif
        capRaw[capIdx] = DataO;
      end
      capIdx++;
    end else begin
      capIdx = 0;
    end
    dutPrev = DataO;
    Rst = r; EnI = en; DataI = d;
    if (r) begin
      eData = 0; eEn = 0; eDone = 0; eLen = 0; eCnt = 0;
      mInFrame = 0; mIdx = 0; mLevel = 0;
    end else if (en) begin
      k = mInFrame ? mIdx : 0;
      coded = (k >= ASM && k < FB) ? (d ^ pn[(k - ASM) % 255]) : d;
`ifdef TM_FRAME_RANDOMIZER_NRZM_EN
      mLevel = mLevel ^ coded;
      eData = mLevel;
`else
      eData = coded;
`endif
      eEn = 1; eDone = 0;
      mIdx = (k < 65535) ? k + 1 : k;
      mInFrame = 1;
    end else begin
      eEn = 0;
      eDone = mInFrame;
      if (mInFrame) begin
        eCnt = 16'(mIdx);
        eLen = (mIdx != FB);
      end
      mInFrame = 0; mIdx = 0;
`ifdef TM_FRAME_RANDOMIZER_NRZM_EN
      eData = mLevel;
`else
      eData = 0;
`endif
    end
    armed = 1;
  endtask

  task automatic fill(input int n, input int mode);
    logic [31:0] asmWord;
    asmWord = 32'h1ACFFC1D;
    for (int i = 0; i < n; i++) begin
      if (i < ASM) din[i] = asmWord[31 - i];
      else if (mode == 0) din[i] = 1'b0;
      else if (mode == 1) din[i] = 1'($urandom_range(0, 1));
      else din[i] = 1'b1;
    end
  endtask

  task automatic send(input int n, input int mode, input int gap);
    fill(n, mode);
    for (int i = 0; i < n; i++) step(0, 1, din[i]);
    for (int g = 0; g < gap; g++) step(0, 0, 0);
  endtask

  function automatic logic [7:0] octOf(input int o, input bit fromIn);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[7 - b] = fromIn ? din[8 * o + b] : capt[8 * o + b];
    return v;
  endfunction

  initial begin
    int n;
    int ones;
    vecs[0]  = '{0, 8'h1A}; vecs[1]  = '{1, 8'hCF}; vecs[2]  = '{2, 8'hFC}; vecs[3]  = '{3, 8'h1D};
    vecs[4]  = '{4, 8'hFF}; vecs[5]  = '{5, 8'h48}; vecs[6]  = '{6, 8'h0E}; vecs[7]  = '{7, 8'hC0};
    vecs[8]  = '{8, 8'h9A}; vecs[9]  = '{9, 8'h0D}; vecs[10] = '{10, 8'h70}; vecs[11] = '{11, 8'hBC};

    for (int i = 0; i < 8; i++) pn[i] = 1'b1;
    for (int i = 8; i < 255; i++) pn[i] = pn[i-1] ^ pn[i-3] ^ pn[i-5] ^ pn[i-8];

    for (int k = 0; k < 3; k++) begin
      step(1, 1, 1);
      @(posedge ClkI); #1;
      chk($sformatf("reset_%0d", k), {12'd0, DataO, EnO, FrameDone, LenErr, BitCountO}, 32'd0);
    end
    step(0, 0, 0);
    flush("reset_idle");

    send(FB, 0, 2);
    chk("nominal_done", FrameDone, 1);
    chk("nominal_cnt", BitCountO, FB);
    chk("nominal_lenerr", LenErr, 0);
    for (int v = 0; v < 12; v++)
      chk($sformatf("nominal_oct%0d", vecs[v].oct), octOf(vecs[v].oct, 0), vecs[v].expOct);
`ifdef TM_FRAME_RANDOMIZER_NRZM_EN
    for (int b = 0; b < 8; b++) chk($sformatf("nrzm_asm_bit%0d", b), capRaw[b], (8'b00010011 >> (7 - b)) & 1);
`endif
    flush("nominal_stream");

    send(1000, 1, 2);
    chk("short_cnt", BitCountO, 1000);
    chk("short_lenerr", LenErr, 1);
    flush("short_stream");

    send(FB, 0, 2);
    chk("restart_lenerr", LenErr, 0);
    chk("restart_pn_oct", octOf(4, 0), 8'hFF);
    flush("restart_stream");

    send(2100, 2, 2);
    chk("long_cnt", BitCountO, 2100);
    chk("long_lenerr", LenErr, 1);
    ones = 0;
    for (int i = FB; i < 2100; i++) ones += int'(capt[i]);
    chk("long_overrun_ones", ones, 52);
    flush("long_stream");

    fill(FB, 1);
    for (int i = 0; i < ASM + 500; i++) step(0, 1, din[i]);
    step(1, 1, din[ASM + 500]);
    @(posedge ClkI); #1;
    chk("abort_reset", {12'd0, DataO, EnO, FrameDone, LenErr, BitCountO}, 32'd0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("abort_nodone", FrameDone, 0);
    flush("abort_stream");

    send(FB, 1, 2);
    chk("abort_next_oct", octOf(4, 0), 8'hFF ^ octOf(4, 1));
    flush("after_abort_stream");

    send(40, 1, 1);
    send(FB, 1, 2);
    chk("b2b_cnt", BitCountO, FB);
    chk("b2b_lenerr", LenErr, 0);
    flush("back_to_back_stream");

    send(5, 1, 2);
    chk("tiny_cnt", BitCountO, 5);
    flush("tiny_stream");

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, MAXB);
      send(n, 1, $urandom_range(1, 3));
      step(0, 0, 0);
      chk($sformatf("rand%0d_cnt", r), BitCountO, n);
      flush($sformatf("rand%0d_stream", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
